// File: rtl/banco_reg_wb.sv
// Register file for the multicycle datapath: 32x32 registers, R0 hardwired to zero,
// registered A/B read ports, combinational debug port and a committed-write counter.
module banco_reg_wb (
  input  logic        clock,
  input  logic        reset,
  input  logic        EscreveReg,
  input  logic        RegDst,
  input  logic [1:0]  MemparaReg,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] AluOut,
  input  logic [31:0] MDR,
  input  logic [15:0] Imm16,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic [4:0]  Dbg_sel,
  output logic [31:0] Dbg_data,
  output logic [15:0] Wr_count
);

  logic [31:0] regs_q [0:31];
  logic [31:0] regs_d [0:31];
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;

  always_comb begin
    wr_addr = RegDst ? rd : rt;
    case (MemparaReg)
      2'b00:   wr_data = AluOut;
      2'b01:   wr_data = MDR;
      2'b10:   wr_data = {Imm16, 16'h0000};
      default: wr_data = 32'h0000_0000;
    endcase
    // R0 writes are dropped here so they neither land nor bump the counter.
    wr_en = EscreveReg && (wr_addr != 5'd0);
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
    regs_d[0] = 32'h0000_0000;
    // Reads sample the pre-write contents: no bypass from the write port.
    a_d = (rs == 5'd0) ? 32'h0000_0000 : regs_q[rs];
    b_d = (rt == 5'd0) ? 32'h0000_0000 : regs_q[rt];
    wr_count_d = wr_en ? (wr_count_q + 16'd1) : wr_count_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
      a_q        <= 32'h0000_0000;
      b_q        <= 32'h0000_0000;
      wr_count_q <= 16'h0000;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      a_q        <= a_d;
      b_q        <= b_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign Wr_count = wr_count_q;
  assign Dbg_data = (Dbg_sel == 5'd0) ? 32'h0000_0000 : regs_q[Dbg_sel];

endmodule

// File: doc/banco_reg_wb.md
BANCO_REG_WB -- requirements
Module: banco_reg_wb

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- EscreveReg  in  1  register write enable from the control unit.
- RegDst  in  1  write address select: 0=rt, 1=rd.
- MemparaReg  in  2  write data select.
- rs  in  5  IR[25:21], source register A.
- rt  in  5  IR[20:16], source register B / I-type destination.
- rd  in  5  IR[15:11], R-type destination.
- AluOut  in  32  ALUOut register value.
- MDR  in  32  memory data register value.
- Imm16  in  16  IR[15:0].
- A  out  32  registered read of R[rs].
- B  out  32  registered read of R[rt].
- Dbg_sel  in  5  debug read address.
- Dbg_data  out  32  combinational debug read of R[Dbg_sel].
- Wr_count  out  16  count of committed register writes.

REQ-002 Reset SHALL be signal reset, asynchronous, active-high. Clock SHALL be signal clock.

Function
REQ-003 The block SHALL hold 32 registers R0..R31, each 32 bits wide.

REQ-004 Write address SHALL be rd when RegDst=1 and rt when RegDst=0.

REQ-005 Write data SHALL be selected by MemparaReg:
- 00: AluOut.
- 01: MDR.
- 10: {Imm16, 16'h0000} (LUI).
- 11: 32'h00000000.

REQ-006 On a rising edge with EscreveReg=1 and write address != 0, the addressed register SHALL take the write data.

REQ-007 Writes to R0 SHALL be discarded. R0 SHALL always read 0 on A, B and Dbg_data.

REQ-008 A SHALL load R[rs] and B SHALL load R[rt] on every rising edge, unconditionally. Latency from rs/rt to A/B SHALL be one cycle.

REQ-009 When the same edge both writes register N and loads A or B from register N, A or B SHALL capture the pre-write value. There is no write-to-read bypass.

REQ-010 A write in cycle k SHALL be visible on A/B after the edge of cycle k+1. It SHALL be visible on Dbg_data immediately after the write edge of cycle k.

REQ-011 Dbg_data SHALL be combinational from Dbg_sel and current register contents, with no clock latency.

REQ-012 Wr_count SHALL increment by 1 on every edge where REQ-006 commits a write. Discarded R0 writes SHALL NOT increment it.

REQ-013 Wr_count SHALL wrap from 16'hFFFF to 16'h0000.

REQ-014 EscreveReg=0 SHALL leave all registers and Wr_count unchanged, regardless of RegDst, MemparaReg and data inputs.

REQ-015 Inputs carrying X while EscreveReg=0 SHALL NOT corrupt stored state.

Reset
REQ-016 While reset=1, the block SHALL asynchronously clear R0..R31, A, B and Wr_count to 0, independent of clock.

REQ-017 Reset asserted during a write edge SHALL win; the write SHALL be lost.

REQ-018 On the first rising edge after reset deasserts, the block SHALL resume normal operation with no extra delay.

Verification
REQ-019 Scenario: reset, then rs=rt=0 for 3 cycles -> A=B=0, Wr_count=0, Dbg_data=0 for every Dbg_sel.

REQ-020 Scenario: EscreveReg=1, RegDst=1, rd=8, MemparaReg=00, AluOut=32'h12345678 for 1 edge; then rs=8 -> Dbg_sel=8 reads 32'h12345678 right after the edge; A=32'h12345678 one edge later; Wr_count=1.

REQ-021 Scenario (LUI path): RegDst=0, rt=9, MemparaReg=10, Imm16=16'hABCD, EscreveReg=1 -> R9=32'hABCD0000. Scenario (MDR path): MemparaReg=01, rt=10, MDR=32'hDEADBEEF -> R10=32'hDEADBEEF.

REQ-022 Scenario: write 32'hFFFFFFFF to R0 with RegDst=1, rd=0 -> Dbg_sel=0 reads 0; A=0 with rs=0; Wr_count unchanged.

REQ-023 Scenario: R5=1, then same edge writes R5=2 with rs=rt=5 -> A=B=1 after that edge; A=B=2 after the next edge.

REQ-024 Scenario: reset pulsed mid-cycle between edges after R3=7 and Wr_count=5 -> R3, A, B and Wr_count read 0 immediately. Also preload Wr_count to 16'hFFFF by forced writes, then one more write -> Wr_count=0.
